// File: rtl/dlf_gear_ctrl_if.sv
// Interface bundling the control and DLF-observation signals of dlf_gear_ctrl.
// master: DPLL top-level side; slave: the gear controller itself.
interface dlf_gear_ctrl_if;
    logic       start;
    logic       stop;
    logic       carry;
    logic       borrow;
    logic       dlfEnable;
    logic       dlfClear;
    logic [3:0] kMode;
    logic       locked;
    logic [1:0] state;

    modport master (
        output start, stop, carry, borrow,
        input  dlfEnable, dlfClear, kMode, locked, state
    );

    modport slave (
        input  start, stop, carry, borrow,
        output dlfEnable, dlfClear, kMode, locked, state
    );
endinterface

// File: rtl/dlf_gear_ctrl.sv
// DPLL loop-filter gear-shift controller: IDLE -> FLUSH -> ACQUIRE (kMode steps) -> TRACK.
// Optional macro DLF_GEAR_RELOCK_EN: falls back from TRACK to ACQUIRE on loss of lock.
module dlf_gear_ctrl #(
    parameter int unsigned WINDOW_LEN    = 1024,
    parameter int unsigned LOCK_THRESH   = 2,
    parameter int unsigned UNLOCK_THRESH = 8,
    parameter int unsigned LOCK_WINDOWS  = 4,
    parameter int unsigned K_MIN         = 1,
    parameter int unsigned K_MAX         = 8
) (
    input logic            clk,
    input logic            reset,
    dlf_gear_ctrl_if.slave bus
);

    localparam int unsigned WW = $clog2(WINDOW_LEN);

    if (WINDOW_LEN < 2 || LOCK_THRESH > 255 || UNLOCK_THRESH > 255 ||
        LOCK_WINDOWS < 1 || LOCK_WINDOWS > 15 ||
        K_MIN < 1 || K_MAX > 15 || K_MIN > K_MAX) begin : g_bad_params
        $error("dlf_gear_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        ACQUIRE = 2'd2,
        TRACK   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    kmode_q, kmode_d;
    logic          enable_q, enable_d;
    logic          clear_q, clear_d;
    logic          locked_q, locked_d;
    logic [WW-1:0] win_q, win_d;
    logic [7:0]    evt_q, evt_d;
    logic [3:0]    quiet_q, quiet_d;
    logic          flush_q, flush_d;

    logic [8:0]    evt_sum;
    logic [7:0]    evt_sat;
    logic [3:0]    quiet_inc;
    logic          win_end;

    always_comb begin
        state_d   = state_q;
        kmode_d   = kmode_q;
        win_d     = win_q;
        evt_d     = evt_q;
        quiet_d   = quiet_q;
        flush_d   = flush_q;

        evt_sum   = {1'b0, evt_q} + 9'(bus.carry) + 9'(bus.borrow);
        evt_sat   = evt_sum[8] ? 8'hFF : evt_sum[7:0];
        quiet_inc = quiet_q + 4'd1;
        win_end   = (win_q == WW'(WINDOW_LEN - 1));

        case (state_q)
            IDLE: begin
                kmode_d = 4'(K_MIN);
                if (bus.start) begin
                    state_d = FLUSH;
                    flush_d = 1'b0;
                    win_d   = '0;
                    evt_d   = '0;
                    quiet_d = '0;
                end
            end
            FLUSH: begin
                if (flush_q) state_d = ACQUIRE;
                else         flush_d = 1'b1;
            end
            ACQUIRE, TRACK: begin
                if (win_end) begin
                    // The window-end cycle's own events are folded in via evt_sat.
                    win_d = '0;
                    evt_d = '0;
                    if (state_q == ACQUIRE) begin
                        if (evt_sat <= 8'(LOCK_THRESH)) begin
                            if (quiet_inc == 4'(LOCK_WINDOWS)) begin
                                quiet_d = '0;
                                if (kmode_q < 4'(K_MAX)) kmode_d = kmode_q + 4'd1;
                                else                     state_d = TRACK;
                            end else begin
                                quiet_d = quiet_inc;
                            end
                        end else begin
                            quiet_d = '0;
                        end
                    end
`ifdef DLF_GEAR_RELOCK_EN
                    else if (evt_sat >= 8'(UNLOCK_THRESH)) begin
                        state_d = ACQUIRE;
                        kmode_d = 4'(K_MIN);
                        quiet_d = '0;
                    end
`endif
                end else begin
                    win_d = win_q + WW'(1);
                    evt_d = evt_sat;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.stop) begin
            state_d = IDLE;
            kmode_d = 4'(K_MIN);
            win_d   = '0;
            evt_d   = '0;
            quiet_d = '0;
            flush_d = 1'b0;
        end

        clear_d  = (state_d == FLUSH);
        enable_d = (state_d == ACQUIRE) || (state_d == TRACK);
        locked_d = (state_d == TRACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            kmode_q  <= 4'(K_MIN);
            enable_q <= 1'b0;
            clear_q  <= 1'b0;
            locked_q <= 1'b0;
            win_q    <= '0;
            evt_q    <= '0;
            quiet_q  <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            kmode_q  <= kmode_d;
            enable_q <= enable_d;
            clear_q  <= clear_d;
            locked_q <= locked_d;
            win_q    <= win_d;
            evt_q    <= evt_d;
            quiet_q  <= quiet_d;
            flush_q  <= flush_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.kMode     = kmode_q;
    assign bus.dlfEnable = enable_q;
    assign bus.dlfClear  = clear_q;
    assign bus.locked    = locked_q;

endmodule

// File: tb/tb_dlf_gear_ctrl.sv
// Directed self-checking bench for dlf_gear_ctrl (WINDOW_LEN=16, LOCK_WINDOWS=2, K 1..3).
// Honours DLF_GEAR_RELOCK_EN to select the expected loss-of-lock behaviour.
module tb_dlf_gear_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    dlf_gear_ctrl_if bus ();

    dlf_gear_ctrl #(
        .WINDOW_LEN   (16),
        .LOCK_THRESH  (1),
        .UNLOCK_THRESH(4),
        .LOCK_WINDOWS (2),
        .K_MIN        (1),
        .K_MAX        (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start in IDLE and advance to the first ACQUIRE cycle (window counter 0).
    task automatic launch();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.carry  = 1'b0;
        bus.borrow = 1'b0;

        // Reset
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_state",  bus.state,     0);
        chk("rst_kmode",  bus.kMode,     1);
        chk("rst_enable", bus.dlfEnable, 0);
        chk("rst_clear",  bus.dlfClear,  0);
        chk("rst_locked", bus.locked,    0);

        // Quiet acquisition
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("flush1_clear",  bus.dlfClear,  1);
        chk("flush1_state",  bus.state,     1);
        chk("flush1_enable", bus.dlfEnable, 0);
        tick();
        chk("flush2_clear",  bus.dlfClear,  1);
        chk("flush2_state",  bus.state,     1);
        tick();
        chk("acq_state",  bus.state,     2);
        chk("acq_enable", bus.dlfEnable, 1);
        chk("acq_clear",  bus.dlfClear,  0);
        chk("acq_kmode",  bus.kMode,     1);
        repeat (31) tick();
        chk("pre_step1_kmode", bus.kMode, 1);
        tick();
        chk("step1_kmode", bus.kMode, 2);
        chk("step1_clear", bus.dlfClear, 0);
        repeat (31) tick();
        chk("pre_step2_kmode", bus.kMode, 2);
        tick();
        chk("step2_kmode", bus.kMode, 3);
        repeat (31) tick();
        chk("pre_track_state", bus.state, 2);
        tick();
        chk("track_state",  bus.state,     3);
        chk("track_locked", bus.locked,    1);
        chk("track_enable", bus.dlfEnable, 1);

        // start ignored outside IDLE, stop from TRACK
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("track_start_state", bus.state,    3);
        chk("track_start_clear", bus.dlfClear, 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop_state",  bus.state,     0);
        chk("stop_locked", bus.locked,    0);
        chk("stop_kmode",  bus.kMode,     1);
        chk("stop_enable", bus.dlfEnable, 0);

        // Noisy loop: 4 events per window for 10 windows
        launch();
        for (int i = 0; i < 160; i++) begin
            bus.carry = (i % 4 == 0);
            tick();
        end
        bus.carry = 1'b0;
        chk("noisy_kmode",  bus.kMode,  1);
        chk("noisy_locked", bus.locked, 0);
        chk("noisy_state",  bus.state,  2);

        // stop and start together mid-ACQUIRE
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        chk("abort_state",  bus.state,     0);
        chk("abort_enable", bus.dlfEnable, 0);
        tick();
        chk("abort_hold_state", bus.state, 0);

        // Quiet counter reset: 1 event (quiet), 3 events ending on window end, quiet, quiet
        launch();
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 16; c++) begin
                bus.carry  = (w == 0 && c == 0) || (w == 1 && c >= 14);
                bus.borrow = (w == 1 && c == 15);
                tick();
            end
            bus.carry  = 1'b0;
            bus.borrow = 1'b0;
            if (w == 2) chk("qreset_w3_kmode", bus.kMode, 1);
        end
        chk("qreset_w4_kmode", bus.kMode, 2);

        // Climb to TRACK, then loss of lock
        repeat (64) tick();
        chk("lol_pre_state",  bus.state,  3);
        chk("lol_pre_locked", bus.locked, 1);
        chk("lol_pre_kmode",  bus.kMode,  3);
        for (int c = 0; c < 16; c++) begin
            bus.carry  = (c == 3 || c == 4);
            bus.borrow = (c == 3 || c == 4);
            if (c == 15) chk("lol_last_cycle_state", bus.state, 3);
            tick();
        end
        bus.carry  = 1'b0;
        bus.borrow = 1'b0;
`ifdef DLF_GEAR_RELOCK_EN
        chk("lol_kmode",  bus.kMode,     1);
        chk("lol_locked", bus.locked,    0);
        chk("lol_state",  bus.state,     2);
        chk("lol_enable", bus.dlfEnable, 1);
        chk("lol_clear",  bus.dlfClear,  0);
`else
        chk("lol_state",  bus.state,  3);
        chk("lol_locked", bus.locked, 1);
        chk("lol_kmode",  bus.kMode,  3);
`endif
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("lol_stop_state", bus.state, 0);

        // Reset mid-FLUSH
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_flush_state", bus.state,    0);
        chk("rst_flush_clear", bus.dlfClear, 0);

        // Reset at window counter 7 of the second window
        launch();
        repeat (23) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_win_state",  bus.state,     0);
        chk("rst_win_enable", bus.dlfEnable, 0);
        chk("rst_win_kmode",  bus.kMode,     1);
        chk("rst_win_locked", bus.locked,    0);

        // Fresh acquisition needs full windows again; start mid-ACQUIRE ignored
        launch();
        repeat (5) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("acq_start_state", bus.state,    2);
        chk("acq_start_clear", bus.dlfClear, 0);
        repeat (25) tick();
        chk("restart_pre_kmode", bus.kMode, 1);
        tick();
        chk("restart_kmode", bus.kMode, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
